// File: rtl/sync_reference_recovery.sv
// sync_reference_recovery: measures the period of an external sync pulse
// train, qualifies lock, and regenerates in-phase / quadrature square
// references (14-bit two's complement) locked to that sync.
// Optional macro SYNC_REF_AVERAGE_EN: while locked, the period estimate
// is a running 4-entry average instead of the latest measurement.
module sync_reference_recovery #(
    parameter int CNT_W      = 24,
    parameter int MIN_PERIOD = 8,
    parameter int MAX_PERIOD = 2**24 - 2,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int REF_AMP    = 8191
) (
    input  logic             dac_clk_i,
    input  logic             dac_rst_i,
    input  logic             sync_i,
    output logic [13:0]      ref_i_o,
    output logic [13:0]      ref_q_o,
    output logic [CNT_W-1:0] period_o,
    output logic             locked_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [13:0]      REF_POS = REF_AMP[13:0];
    localparam logic [13:0]      REF_NEG = ~REF_POS + 14'd1;
    localparam logic [CNT_W:0]   MIN_P   = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W:0]   MAX_P   = (CNT_W+1)'(MAX_PERIOD);
    localparam logic [CNT_W:0]   TOL_P   = (CNT_W+1)'(TOL);
    localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [MW-1:0]    match_q, match_d;
    logic             locked_q;
    logic [13:0]      ref_i_q, ref_i_d, ref_q_q, ref_q_d;

    logic             edge_s, in_range_s, match_hit_s, timeout_s;
    logic [CNT_W:0]   meas_s, per_ext_s, diff_s;
    logic [CNT_W-1:0] half_s, qtr_s, three_qtr_s, avg_s;
    logic             hist_fill_s, hist_shift_s;

    // Period measurement arithmetic, kept one bit wider so meas never wraps
    always_comb begin
        edge_s      = sync_i & ~sync_q;
        meas_s      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        per_ext_s   = {1'b0, period_q};
        in_range_s  = (meas_s >= MIN_P) && (meas_s <= MAX_P);
        if (meas_s >= per_ext_s) begin
            diff_s = meas_s - per_ext_s;
        end else begin
            diff_s = per_ext_s - meas_s;
        end
        match_hit_s = (diff_s <= TOL_P);
        timeout_s   = ({1'b0, cnt_q} > {period_q, 1'b0});
        if (edge_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef SYNC_REF_AVERAGE_EN
    // History holds the three entries that survive alongside the newest one
    logic [CNT_W-1:0] hist_q [3];
    logic [CNT_W+1:0] sum_s;

    // Running average of the new measurement and the three previous entries
    always_comb begin
        sum_s = {1'b0, meas_s} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
              + {2'b00, hist_q[2]};
        avg_s = sum_s[CNT_W+1:2];
    end

    // History shift register: preload on lock entry, shift on matching edges
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            for (int i = 0; i < 3; i++) hist_q[i] <= {CNT_W{1'b0}};
        end else if (hist_fill_s) begin
            for (int i = 0; i < 3; i++) hist_q[i] <= period_q;
        end else if (hist_shift_s) begin
            hist_q[0] <= meas_s[CNT_W-1:0];
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
        end else begin
            for (int i = 0; i < 3; i++) hist_q[i] <= hist_q[i];
        end
    end
`else
    // Without averaging the locked estimate simply follows each measurement
    always_comb begin
        avg_s = meas_s[CNT_W-1:0];
    end
`endif

    // Lock FSM next-state and period/match bookkeeping; an edge beats timeout
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        match_d      = match_q;
        hist_fill_s  = 1'b0;
        hist_shift_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (edge_s && in_range_s) begin
                    period_d = meas_s[CNT_W-1:0];
                    match_d  = {MW{1'b0}};
                    state_d  = ST_TRACK;
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_TRACK: begin
                if (edge_s) begin
                    if (match_hit_s) begin
                        match_d = match_q + {{(MW-1){1'b0}}, 1'b1};
                        if (match_d == LOCK_N) begin
                            state_d     = ST_LOCKED;
                            hist_fill_s = 1'b1;
                        end else begin
                            state_d = ST_TRACK;
                        end
                    end else if (in_range_s) begin
                        period_d = meas_s[CNT_W-1:0];
                        match_d  = {MW{1'b0}};
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (edge_s) begin
                    if (match_hit_s) begin
                        period_d     = avg_s;
                        hist_shift_s = 1'b1;
                    end else if (in_range_s) begin
                        period_d = meas_s[CNT_W-1:0];
                        match_d  = {MW{1'b0}};
                        state_d  = ST_TRACK;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Square references derived from the phase counter while locked
    always_comb begin
        half_s      = period_q >> 1;
        qtr_s       = period_q >> 2;
        three_qtr_s = qtr_s + (qtr_s << 1);
        if (state_q == ST_LOCKED) begin
            ref_i_d = (cnt_q < half_s) ? REF_POS : REF_NEG;
            ref_q_d = ((cnt_q >= qtr_s) && (cnt_q < three_qtr_s)) ? REF_POS : REF_NEG;
        end else begin
            ref_i_d = 14'd0;
            ref_q_d = 14'd0;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q  <= ST_IDLE;
            sync_q   <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            period_q <= {CNT_W{1'b0}};
            match_q  <= {MW{1'b0}};
            locked_q <= 1'b0;
            ref_i_q  <= 14'd0;
            ref_q_q  <= 14'd0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_i;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            match_q  <= match_d;
            locked_q <= (state_d == ST_LOCKED);
            ref_i_q  <= ref_i_d;
            ref_q_q  <= ref_q_d;
        end
    end

    assign ref_i_o  = ref_i_q;
    assign ref_q_o  = ref_q_q;
    assign period_o = period_q;
    assign locked_o = locked_q;

endmodule

// File: tb/tb_sync_reference_recovery.sv
// Scoreboard bench for sync_reference_recovery: a cycle-level behavioural
// model predicts every output sample; a monitor compares the DUT against it.
module tb_sync_reference_recovery;

    localparam int AMP     = 8191;
    localparam int MAXP    = 2**24 - 2;
    localparam int CNTSAT  = 2**24 - 1;
    localparam int M_IDLE  = 0;
    localparam int M_MEAS  = 1;
    localparam int M_TRACK = 2;
    localparam int M_LOCK  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic [13:0] ref_i, ref_q;
    logic [23:0] period;
    logic        locked;

    sync_reference_recovery dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .sync_i    (sync),
        .ref_i_o   (ref_i),
        .ref_q_o   (ref_q),
        .period_o  (period),
        .locked_o  (locked)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [13:0] ri;
        logic [13:0] rq;
        logic [23:0] per;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // behavioural model state
    int m_st = M_IDLE, m_cnt = 0, m_prev = 0, m_per = 0, m_match = 0;
    int m_ri = 0, m_rq = 0, m_lk = 0;
    int hist[$];

    task automatic model_step(input bit s, input bit r);
        bit e, inr, hit, tmo;
        int meas, diff, nst, sum;
        if (r) begin
            m_st = M_IDLE; m_cnt = 0; m_prev = 0; m_per = 0; m_match = 0;
            m_ri = 0; m_rq = 0; m_lk = 0;
            hist.delete();
        end else begin
            e    = s && (m_prev == 0);
            meas = m_cnt + 1;
            inr  = (meas >= 8) && (meas <= MAXP);
            diff = (meas > m_per) ? meas - m_per : m_per - meas;
            hit  = diff <= 2;
            tmo  = m_cnt > 2 * m_per;
            if (m_st == M_LOCK) begin
                m_ri = (m_cnt < m_per / 2) ? AMP : -AMP;
                m_rq = (m_cnt >= m_per / 4 && m_cnt < 3 * (m_per / 4)) ? AMP : -AMP;
            end else begin
                m_ri = 0;
                m_rq = 0;
            end
            nst = m_st;
            if (m_st == M_IDLE) begin
                if (e) nst = M_MEAS;
            end else if (m_st == M_MEAS) begin
                if (e && inr) begin
                    m_per = meas; m_match = 0; nst = M_TRACK;
                end
            end else if (e) begin
                if (hit && m_st == M_TRACK) begin
                    m_match++;
                    if (m_match == 4) begin
                        nst = M_LOCK;
                        hist = '{m_per, m_per, m_per, m_per};
                    end
                end else if (hit) begin
`ifdef SYNC_REF_AVERAGE_EN
                    hist.push_front(meas);
                    void'(hist.pop_back());
                    sum = 0;
                    foreach (hist[i]) sum += hist[i];
                    m_per = sum / 4;
`else
                    sum = 0;
                    m_per = meas + sum;
`endif
                end else if (inr) begin
                    m_per = meas; m_match = 0; nst = M_TRACK;
                end else begin
                    nst = M_MEAS;
                end
            end else if (tmo) begin
                nst = M_IDLE;
            end
            m_cnt  = e ? 0 : ((m_cnt == CNTSAT) ? CNTSAT : m_cnt + 1);
            m_prev = s;
            m_st   = nst;
            m_lk   = (nst == M_LOCK) ? 1 : 0;
        end
    endtask

    // One clock of stimulus: drive away from the edge, predict, enqueue
    task automatic tick(input bit s, input bit r);
        exp_t x;
        @(negedge clk);
        sync = s;
        rst  = r;
        model_step(s, r);
        x.ri  = m_ri[13:0];
        x.rq  = m_rq[13:0];
        x.per = m_per[23:0];
        x.lk  = m_lk[0];
        sb.push_back(x);
    endtask

    // n sync periods of the given length with a random 1-2 clock pulse
    task automatic pulses(input int per, input int n);
        int w;
        for (int p = 0; p < n; p++) begin
            w = 1 + int'($urandom % 2);
            for (int k = 0; k < per; k++) tick(k < w, 1'b0);
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every clock the DUT presents a new output sample
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("ref_i", int'($signed(ref_i)), int'($signed(x.ri)));
                check("ref_q", int'($signed(ref_q)), int'($signed(x.rq)));
                check("period", int'(period), int'(x.per));
                check("locked", int'(locked), int'(x.lk));
            end
        end
    end

    initial begin
        int per;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        // lock at 100 and observe the references over several periods
        pulses(100, 10);
        // alternating 101 / 99 while locked
        for (int i = 0; i < 4; i++) begin
            pulses(101, 1);
            pulses(99, 1);
        end
        // jump to 150, then relock
        pulses(150, 7);
        // sync stops: timeout back to idle
        for (int i = 0; i < 400; i++) tick(1'b0, 1'b0);
        // a 4-clock train is out of range and never leaves measure
        pulses(4, 20);
        // relock at 100, reset pulse mid-lock, relock again
        pulses(100, 8);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        pulses(100, 8);
        // randomized periods with jitter
        for (int r = 0; r < 20; r++) begin
            per = 8 + int'($urandom % 53);
            for (int j = 0; j < 1 + int'($urandom % 8); j++) begin
                pulses(per + int'($urandom % 5) - 2, 1);
            end
            if (($urandom % 4) == 0) begin
                for (int i = 0; i < 3 * per; i++) tick(1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_reference_recovery.md
Name: sync_reference_recovery

Overview:
- Receive-side counterpart of the signal generator's sync output.
- Measures the period of the incoming sync pulse train and qualifies lock.
- Regenerates in-phase and quadrature square reference waveforms locked to the sync, in 14-bit two's-complement DAC format.
- Lets the lock-in amplifier take its inPhase/outPhase references from an external sync instead of the on-chip generator.

Parameters:
CNT_W, 24, width of the period counter and period_o
MIN_PERIOD, 8, smallest accepted period in clocks
MAX_PERIOD, 2**24-2, largest accepted period in clocks
TOL, 2, allowed |measured - stored period| for a match, in clocks
LOCK_COUNT, 4, consecutive matches needed to declare lock
REF_AMP, 8191, positive reference amplitude; negative level is -REF_AMP

Ports:
dac_clk_i  input  1  125 MHz clock, the only clock
dac_rst_i  input  1  reset, synchronous, active-high
sync_i  input  1  sync pulse train, synchronous to dac_clk_i
ref_i_o  output  14  in-phase square reference, signed
ref_q_o  output  14  quadrature reference, lagging ref_i_o by 90 deg, signed
period_o  output  CNT_W  current period estimate in clocks
locked_o  output  1  high while state is LOCKED

Behaviour:
- Reset: every register is cleared and state = IDLE. ref_i_o = ref_q_o = 0, period_o = 0, locked_o = 0, cnt = 0, match = 0, previous-sync register = 0. A reset asserted mid-operation takes effect on the next clock edge and overrides everything.
- Edge detect: edge = sync_i & ~sync_q, where sync_q is sync_i registered one clock.
- Counter, on an edge cycle: meas = cnt + 1, then cnt <= 0.
- Counter, otherwise: cnt <= cnt + 1, saturating at all-ones.
- Result: with edges every P clocks, meas = P.
- in_range: MIN_PERIOD <= meas <= MAX_PERIOD.
- match: |meas - period_o| <= TOL. The compare is unsigned, using the absolute difference.
- Timeout: cnt > 2*period_o, computed at CNT_W+1 bits. Timeout is evaluated only in TRACK and LOCKED.
- State IDLE: on edge, go to MEASURE.
- State MEASURE:
  - edge and in_range: period_o <= meas, match <= 0, go to TRACK.
  - edge and not in_range: stay in MEASURE.
- State TRACK, on an edge:
  - match: match <= match + 1. When match + 1 == LOCK_COUNT, go to LOCKED.
  - no match but in_range: period_o <= meas, match <= 0, stay in TRACK.
  - not in_range: go to MEASURE.
- State TRACK, timeout with no edge: go to IDLE.
- State LOCKED, on an edge:
  - match: period_o <= meas (or the average, see Optional Feature), stay in LOCKED.
  - no match but in_range: period_o <= meas, match <= 0, go to TRACK.
  - not in_range: go to MEASURE.
- State LOCKED, timeout with no edge: go to IDLE.
- Edge and timeout in the same cycle: the edge wins.
- locked_o is registered: it is high from the cycle after entry into LOCKED and low from the cycle after leaving it.
- References when in LOCKED, with h = period_o>>1, q = period_o>>2, t = q + (q<<1):
  - ref_i_o = +REF_AMP if cnt < h, else -REF_AMP.
  - ref_q_o = +REF_AMP if q <= cnt < t, else -REF_AMP.
  - Both are registered, one clock after cnt.
- References in any other state: ref_i_o = ref_q_o = 0, registered.

Optional Feature:
- Macro: SYNC_REF_AVERAGE_EN.
- When defined: in LOCKED, a matching edge writes meas into a 4-entry history and sets period_o = (sum of the 4 entries) >> 2. The sum is held at CNT_W+2 bits. The history is filled with period_o on entry to LOCKED.
- When undefined: period_o <= meas on every matching edge. No history registers are instantiated.
- In both builds, match/timeout decisions use the current period_o.

Test Plan:
- Sync pulses every 100 clocks after reset:
  - period_o = 100 after edge 2.
  - locked_o rises the cycle after edge 6 (edge 1 -> MEASURE, edge 2 -> TRACK, edges 3-6 = 4 matches).
- Locked at period 100:
  - ref_i_o = +8191 for cnt 0-49 and -8191 for cnt 50-99.
  - ref_q_o = +8191 for cnt 25-74 and -8191 otherwise.
  - Both outputs lag cnt by 1 clock.
- Locked, periods alternating 101 and 99:
  - locked_o stays 1.
  - Without the macro, period_o follows each edge. With SYNC_REF_AVERAGE_EN, period_o = 100 after 4 edges.
- Locked, period jumps to 150:
  - locked_o falls one clock after the jump edge; state TRACK, period_o = 150, refs 0.
  - Relock after 4 further 150-clock edges.
- Locked at 100, sync stops:
  - Once cnt reaches 201: state IDLE, locked_o = 0, refs = 0.
  - Separately: a 4-clock sync train never leaves MEASURE.
- dac_rst_i pulsed for 1 clock while LOCKED:
  - The next cycle shows all outputs 0 and state IDLE.
  - The full lock sequence is then required again.
